gpio_apb_regs: RTL and testbench

//  APB3 register bank that is the software-facing end of gpio_controller's control interface.

---
 rtl/gpio_pkg.sv | 48 ++++
 rtl/gpio_sync2.sv | 27 ++
 rtl/gpio_apb_regs.sv | 169 ++++++++++++++++
 tb/tb_gpio_apb_regs.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO APB register bank: register offsets, CTRL bit and FSM encoding.
// The atomic OUT_SET/OUT_CLR/OUT_TGL offsets exist only when GPIO_ATOMIC_EN is defined.
package gpio_pkg;

    localparam logic [7:0] OFF_DIR        = 8'h00;
    localparam logic [7:0] OFF_OUT        = 8'h04;
    localparam logic [7:0] OFF_IN         = 8'h08;
    localparam logic [7:0] OFF_INT_EN     = 8'h0C;
    localparam logic [7:0] OFF_INT_TYPE   = 8'h10;
    localparam logic [7:0] OFF_INT_POL    = 8'h14;
    localparam logic [7:0] OFF_INT_STATUS = 8'h18;
    localparam logic [7:0] OFF_INT_PEND   = 8'h1C;
    localparam logic [7:0] OFF_CTRL       = 8'h20;
`ifdef GPIO_ATOMIC_EN
    localparam logic [7:0] OFF_OUT_SET    = 8'h24;
    localparam logic [7:0] OFF_OUT_CLR    = 8'h28;
    localparam logic [7:0] OFF_OUT_TGL    = 8'h2C;
`endif

    localparam int CTRL_GIE_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } apb_state_e;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_DIR,
        SEL_OUT,
        SEL_IN,
        SEL_INT_EN,
        SEL_INT_TYPE,
        SEL_INT_POL,
        SEL_INT_STATUS,
        SEL_INT_PEND,
        SEL_CTRL,
        SEL_OUT_SET,
        SEL_OUT_CLR,
        SEL_OUT_TGL
    } reg_sel_e;

    function automatic logic is_read_only(input reg_sel_e sel);
        return (sel == SEL_IN) || (sel == SEL_INT_PEND);
    endfunction

endpackage

// File: rtl/gpio_sync2.sv
// Parameterised two-flop synchroniser for the asynchronous gpio_in pin levels.
module gpio_sync2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: non-blocking assignments so the second stage takes the first stage's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/gpio_apb_regs.sv
// APB3 register bank in front of gpio_controller: APB FSM, decode, registers, W1C clear pulse, irq.
// Define GPIO_ATOMIC_EN to add the write-only OUT_SET / OUT_CLR / OUT_TGL registers.
module gpio_apb_regs
    import gpio_pkg::*;
#(
    parameter int          PIN_COUNT  = 32,
    parameter int          ADDR_WIDTH = 6,
    parameter logic [31:0] OUT_RESET  = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [PIN_COUNT-1:0]  gpio_dir,
    output logic [PIN_COUNT-1:0]  gpio_out,
    input  logic [PIN_COUNT-1:0]  gpio_in,
    output logic [PIN_COUNT-1:0]  int_enable,
    output logic [PIN_COUNT-1:0]  int_type,
    output logic [PIN_COUNT-1:0]  int_polarity,
    input  logic [PIN_COUNT-1:0]  int_status,
    output logic [PIN_COUNT-1:0]  int_clear,
    input  logic                  int_out,
    output logic                  irq
);

    apb_state_e state_q, state_d;
    reg_sel_e   sel;
    logic       addr_err;
    logic       wr_commit;
    logic [31:0] rdata;
    logic [31:0] prdata_q;
    logic        pslverr_q;

    logic [PIN_COUNT-1:0] dir_q, out_q, int_en_q, int_type_q, int_pol_q, int_clear_q;
    logic                 gie_q, irq_q;
    logic [PIN_COUNT-1:0] gpio_in_sync;
    logic [PIN_COUNT-1:0] wdata;

    assign wdata = pwdata[PIN_COUNT-1:0];

    gpio_sync2 #(.WIDTH(PIN_COUNT)) u_in_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gpio_in),
        .q     (gpio_in_sync)
    );

    // Misaligned addresses never match an offset, so they fall into SEL_NONE.
    always_comb begin
        sel = SEL_NONE;
        case (paddr)
            ADDR_WIDTH'(OFF_DIR):        sel = SEL_DIR;
            ADDR_WIDTH'(OFF_OUT):        sel = SEL_OUT;
            ADDR_WIDTH'(OFF_IN):         sel = SEL_IN;
            ADDR_WIDTH'(OFF_INT_EN):     sel = SEL_INT_EN;
            ADDR_WIDTH'(OFF_INT_TYPE):   sel = SEL_INT_TYPE;
            ADDR_WIDTH'(OFF_INT_POL):    sel = SEL_INT_POL;
            ADDR_WIDTH'(OFF_INT_STATUS): sel = SEL_INT_STATUS;
            ADDR_WIDTH'(OFF_INT_PEND):   sel = SEL_INT_PEND;
            ADDR_WIDTH'(OFF_CTRL):       sel = SEL_CTRL;
`ifdef GPIO_ATOMIC_EN
            ADDR_WIDTH'(OFF_OUT_SET):    sel = SEL_OUT_SET;
            ADDR_WIDTH'(OFF_OUT_CLR):    sel = SEL_OUT_CLR;
            ADDR_WIDTH'(OFF_OUT_TGL):    sel = SEL_OUT_TGL;
`endif
            default:                     sel = SEL_NONE;
        endcase
    end

    assign addr_err = (sel == SEL_NONE) || (pwrite && is_read_only(sel));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rdata = '0;
        case (sel)
            SEL_DIR:        rdata = 32'(dir_q);
            SEL_OUT:        rdata = 32'(out_q);
            SEL_IN:         rdata = 32'(gpio_in_sync);
            SEL_INT_EN:     rdata = 32'(int_en_q);
            SEL_INT_TYPE:   rdata = 32'(int_type_q);
            SEL_INT_POL:    rdata = 32'(int_pol_q);
            SEL_INT_STATUS: rdata = 32'(int_status);
            SEL_INT_PEND:   rdata = 32'(int_status & int_en_q);
            SEL_CTRL:       rdata[CTRL_GIE_BIT] = gie_q;
            default:        rdata = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (psel && !penable) state_d = ST_SETUP;
            ST_SETUP:  state_d = psel ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_d = (psel && !penable) ? ST_SETUP : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign wr_commit = (state_q == ST_ACCESS) && psel && penable && pwrite && !addr_err;

    // Response is captured at the end of SETUP; any other edge clears it back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_SETUP && psel) begin
                prdata_q  <= (pwrite || addr_err) ? 32'h0 : rdata;
                pslverr_q <= addr_err;
            end else begin
                prdata_q  <= '0;
                pslverr_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q       <= '0;
            out_q       <= OUT_RESET[PIN_COUNT-1:0];
            int_en_q    <= '0;
            int_type_q  <= '0;
            int_pol_q   <= '0;
            gie_q       <= 1'b0;
            int_clear_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            int_clear_q <= '0;
            irq_q       <= int_out & gie_q;
            if (wr_commit) begin
                case (sel)
                    SEL_DIR:        dir_q       <= wdata;
                    SEL_OUT:        out_q       <= wdata;
                    SEL_INT_EN:     int_en_q    <= wdata;
                    SEL_INT_TYPE:   int_type_q  <= wdata;
                    SEL_INT_POL:    int_pol_q   <= wdata;
                    SEL_INT_STATUS: int_clear_q <= wdata;
                    SEL_CTRL:       gie_q       <= pwdata[CTRL_GIE_BIT];
`ifdef GPIO_ATOMIC_EN
                    SEL_OUT_SET:    out_q       <= out_q | wdata;
                    SEL_OUT_CLR:    out_q       <= out_q & ~wdata;
                    SEL_OUT_TGL:    out_q       <= out_q ^ wdata;
`endif
                    default:        ;
                endcase
            end
        end
    end

    assign prdata       = prdata_q;
    assign pready       = (state_q == ST_ACCESS);
    assign pslverr      = pslverr_q;
    assign gpio_dir     = dir_q;
    assign gpio_out     = out_q;
    assign int_enable   = int_en_q;
    assign int_type     = int_type_q;
    assign int_polarity = int_pol_q;
    assign int_clear    = int_clear_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_apb_regs.sv
// Self-checking bench for gpio_apb_regs: directed scenarios plus random APB traffic vs a register-map model.
// Honours GPIO_ATOMIC_EN the same way as the design.
module tb_gpio_apb_regs;

    localparam int          P       = 32;
    localparam int          AW      = 6;
    localparam logic [31:0] OUT_RST = 32'h8000_00C3;
    localparam logic [31:0] PMASK   = 32'((64'd1 << P) - 1);
`ifdef GPIO_ATOMIC_EN
    localparam bit ATOMIC = 1'b1;
`else
    localparam bit ATOMIC = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata, prdata;
    logic          pready, pslverr;
    logic [P-1:0]  gpio_dir, gpio_out, gpio_in;
    logic [P-1:0]  int_enable, int_type, int_polarity, int_status, int_clear;
    logic          int_out, irq;

    gpio_apb_regs #(.PIN_COUNT(P), .ADDR_WIDTH(AW), .OUT_RESET(OUT_RST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .gpio_dir     (gpio_dir),
        .gpio_out     (gpio_out),
        .gpio_in      (gpio_in),
        .int_enable   (int_enable),
        .int_type     (int_type),
        .int_polarity (int_polarity),
        .int_status   (int_status),
        .int_clear    (int_clear),
        .int_out      (int_out),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Register-map model: values software last wrote.
    logic [31:0] m_dir, m_out, m_en, m_type, m_pol;
    logic        m_gie;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_dir = 0; m_out = OUT_RST & PMASK; m_en = 0; m_type = 0; m_pol = 0; m_gie = 1'b0;
    endtask

    function automatic bit model_mapped(input logic [5:0] a);
        int top;
        top = ATOMIC ? 'h2C : 'h20;
        return (a % 4 == 0) && (int'(a) <= top);
    endfunction

    task automatic model_xfer(input bit wr, input logic [5:0] a, input logic [31:0] d,
                              output bit e_err, output logic [31:0] e_rd, output logic [31:0] e_clr);
        logic [31:0] dm;
        dm    = d & PMASK;
        e_rd  = 0;
        e_clr = 0;
        e_err = !model_mapped(a) || (wr && (a == 6'h08 || a == 6'h1C));
        if (e_err) return;
        if (!wr) begin
            case (a)
                6'h00: e_rd = m_dir;
                6'h04: e_rd = m_out;
                6'h08: e_rd = 32'(gpio_in);
                6'h0C: e_rd = m_en;
                6'h10: e_rd = m_type;
                6'h14: e_rd = m_pol;
                6'h18: e_rd = 32'(int_status);
                6'h1C: e_rd = 32'(int_status) & m_en;
                6'h20: e_rd = {31'b0, m_gie};
                default: e_rd = 0;
            endcase
        end else begin
            case (a)
                6'h00: m_dir  = dm;
                6'h04: m_out  = dm;
                6'h0C: m_en   = dm;
                6'h10: m_type = dm;
                6'h14: m_pol  = dm;
                6'h18: e_clr  = dm;
                6'h20: m_gie  = d[0];
                6'h24: m_out  = m_out | dm;
                6'h28: m_out  = m_out & ~dm;
                6'h2C: m_out  = m_out ^ dm;
                default: ;
            endcase
        end
    endtask

    // One APB transfer; returns the response seen while pready is high.
    task automatic apb(input bit wr, input logic [5:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
        int cyc;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 0;
        while (pready !== 1'b1 && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("apb.wait_cycles", cyc, 1);
        rd  = prdata;
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".gpio_dir"},     32'(gpio_dir),     m_dir);
        check({tag, ".gpio_out"},     32'(gpio_out),     m_out);
        check({tag, ".int_enable"},   32'(int_enable),   m_en);
        check({tag, ".int_type"},     32'(int_type),     m_type);
        check({tag, ".int_polarity"}, 32'(int_polarity), m_pol);
    endtask

    task automatic txn(input bit wr, input logic [5:0] a, input logic [31:0] d, input string tag);
        bit          e_err;
        logic [31:0] e_rd, e_clr, rd;
        logic        err, old_gie;
        old_gie = m_gie;
        model_xfer(wr, a, d, e_err, e_rd, e_clr);
        apb(wr, a, d, rd, err);
        check({tag, ".pslverr"},   32'(err), 32'(e_err));
        check({tag, ".prdata"},    rd, e_rd);
        check({tag, ".int_clear"}, 32'(int_clear), e_clr);
        check({tag, ".irq"},       32'(irq), 32'(int_out & old_gie));
        check_regs(tag);
        @(posedge clk); #1;
        check({tag, ".int_clear_after"}, 32'(int_clear), 32'h0);
        check({tag, ".irq_after"},       32'(irq), 32'(int_out & m_gie));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".prdata"},  prdata, 32'h0);
        check({tag, ".pready"},  32'(pready), 32'h0);
        check({tag, ".pslverr"}, 32'(pslverr), 32'h0);
        check({tag, ".int_clear"}, 32'(int_clear), 32'h0);
        check({tag, ".irq"},     32'(irq), 32'h0);
        check_regs(tag);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0]  a;
        logic [31:0] rd;
        logic        err;
        rst_n = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        gpio_in = 0; int_status = 0; int_out = 0;
        model_reset();

        // 1: reset values, then read every register
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        release_reset();
        for (int i = 0; i <= 8; i++) txn(1'b0, 6'(i * 4), 32'h0, "rd_all");

        // 2: DIR write/readback
        txn(1'b1, 6'h00, 32'h0000_00FF, "dir_wr");
        check("dir_value", 32'(gpio_dir), 32'h0000_00FF);
        txn(1'b0, 6'h00, 32'h0, "dir_rd");

        // 3: IN via synchroniser
        gpio_in = 32'hA5A5_A5A5;
        repeat (3) @(posedge clk);
        txn(1'b0, 6'h08, 32'h0, "in_rd");

        // 4: W1C pulse, pending, global enable
        int_status = 32'h3;
        txn(1'b1, 6'h18, 32'h1, "status_w1c");
        txn(1'b1, 6'h0C, 32'h2, "int_en_wr");
        txn(1'b0, 6'h1C, 32'h0, "pend_rd");
        int_out = 1'b1;
        repeat (2) @(posedge clk);
        txn(1'b1, 6'h20, 32'h0, "gie_off");
        txn(1'b1, 6'h20, 32'h1, "gie_on");
        check("irq_gie_on", 32'(irq), 32'h1);

        // 5: error responses
        txn(1'b0, 6'h3C, 32'h0, "err_rd_3c");
        txn(1'b1, 6'h09, 32'hDEAD_BEEF, "err_wr_09");
        txn(1'b1, 6'h08, 32'hDEAD_BEEF, "err_wr_in");

        // 6: atomic OUT operations (or errors without the feature)
        txn(1'b1, 6'h04, 32'h0000_00F0, "out_wr");
        txn(1'b1, 6'h24, 32'h0000_000F, "out_set");
        txn(1'b1, 6'h28, 32'h0000_0030, "out_clr");
        txn(1'b1, 6'h2C, 32'h0000_0081, "out_tgl");
        check("out_atomic_result", 32'(gpio_out), ATOMIC ? 32'h0000_004E : 32'h0000_00F0);
        txn(1'b0, 6'h24, 32'h0, "out_set_rd");

        // penable without a setup phase is ignored
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 6'h00; pwdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("no_setup.pready", 32'(pready), 32'h0);
        end
        psel = 1'b0; penable = 1'b0;
        check("no_setup.gpio_dir", 32'(gpio_dir), m_dir);

        // psel dropped after setup: no commit
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h00; pwdata = 32'h5555_5555;
        @(posedge clk); #1;
        psel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort.pready", 32'(pready), 32'h0);
        end
        check("abort.gpio_dir", 32'(gpio_dir), m_dir);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                gpio_in    = $urandom;
                int_status = $urandom;
                int_out    = 1'($urandom_range(0, 1));
                repeat (3) @(posedge clk);
            end
            a = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            txn(1'($urandom_range(0, 1)), a, $urandom, "rand");
        end

        // reset in the middle of a write
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h04; pwdata = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("mid_reset");
        psel = 1'b0; penable = 1'b0;
        release_reset();
        check_reset_outputs("post_reset");
        for (int i = 0; i < 20; i++) begin
            a = 6'($urandom_range(0, 11) * 4);
            txn(1'($urandom_range(0, 1)), a, $urandom, "rand2");
        end
        apb(1'b0, 6'h04, 32'h0, rd, err);
        check("final_out_rd", rd, m_out);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
